lc3_pipe_controller: RTL and testbench
======================================

// Module: lc3_pipe_controller
// PURPOSE
// - Sequencer for the LC3 F/D/E/W pipeline. Drives enable_fetch/enable_updatepc/br_taken into fetch and stage enables downstream.
// - Tracks per-stage opcodes internally, captured from imem_dout.
// - Stalls fetch on control ops (BR/JMP) until resolution.
// - Freezes the pipeline while the data-memory FSM serves LD/LDR/LDI/ST/STR/STI.
// PARAMETERS
// - MEM_TIMEOUT  64  max cycles per data access before abort (only with LC3_CTRL_MEM_TIMEOUT_EN)
// PORTS
// - clock            in   1   single clock, rising edge
// - reset            in   1   synchronous, active-high
// - imem_dout        in   16  instruction currently returned by instr memory (same cycle as enable_fetch)
// - nzp              in   3   registered condition codes from writeback
// - complete_data    in   1   data memory access finished this cycle
// - enable_fetch     out  1   fetch issues instrmem read
// - enable_updatepc  out  1   fetch loads pc (taddr if br_taken else pc+1)
// - br_taken         out  1   select taddr on update
// - enable_decode    out  1   decode stage active
// - enable_execute   out  1   execute stage active
// - enable_writeback out  1   regfile/CC write
// - mem_state        out  2   3=idle 0=read 1=read-indirect 2=write
// - mem_err          out  1   access timeout pulse (0 without macro)
// BEHAVIOUR
// - Reset: while reset=1 and on the next edge, all enables=0, br_taken=0, mem_state=3, mem_err=0.
//   - Valid bits vd/ve/vw=0; FSM=RUN; mid-operation reset aborts any stall or memory access.
//   - First cycle after reset: enable_fetch=1.
// - FSM states: RUN, BR_WAIT, MEM_IND, MEM_RD, MEM_WR.
// - RUN, no hazard: enable_fetch=1; enable_updatepc=1.
//   - Advance: vd<=1, op_d<=imem_dout[15:9], ve<=vd, vw<=ve.
//   - enable_decode=vd; enable_execute=ve; enable_writeback=vw & regwrite(op_w).
// - regwrite ops: ADD 0001, AND 0101, NOT 1001, LD 0010, LDR 0110, LDI 1010, LEA 1110.
//   - All others write nothing.
//   - TRAP/RTI/JSR/reserved pass through as NOP.
// - Control hazard: cycle t, enable_fetch=1 and imem_dout[15:12] in {0000 BR, 1100 JMP}:
//   - At t: enable_updatepc=0; FSM->BR_WAIT.
//   - t+1, t+2: enable_fetch=enable_updatepc=0; bubbles (vd<=0); branch goes D (t+1) then E (t+2).
//   - t+3 (resolve): enable_updatepc=1; br_taken = JMP ? 1 : |(cond[11:9] & nzp); FSM->RUN.
//   - t+4: fetch resumes. Penalty: 3 bubbles.
// - Memory op in E (ve=1, op_e in LD/LDR/LDI/ST/STR/STI) at cycle e:
//   - At e: enable_execute=1 (address calc); enable_fetch/enable_updatepc/enable_decode=0; vw<=0.
//   - Next state: LDI/STI->MEM_IND; LD/LDR/LDI 2nd access->MEM_RD; ST/STR/STI 2nd access->MEM_WR.
//   - In MEM_*: all enables=0; vd/ve/op regs hold; mem_state per encoding.
//   - Each state waits for complete_data. MEM_IND + complete_data -> MEM_RD (LDI) or MEM_WR (STI).
//   - Final complete_data: FSM->RUN; op advances to W (vw<=1, op_w<=op_e).
//   - Loads get enable_writeback next cycle.
// - complete_data outside MEM_* is ignored.
// - Priority: reset > memory freeze > control hazard > normal.
//   - imem_dout is sampled only when enable_fetch=1.
// - Outputs are combinational from registered state/valids; imem_dout feeds only enable_updatepc/op capture.
// CONFIGURATION
// - LC3_CTRL_MEM_TIMEOUT_EN defined:
//   - Counter clears on MEM_* entry and on each complete_data.
//   - Reaching MEM_TIMEOUT cycles in a MEM_* state: mem_err=1 for one cycle; FSM->RUN; mem op dropped (vw<=0, no writeback).
// - Undefined: no counter; MEM_* waits forever; mem_err tied 0.
// TESTING
// - Reset 3 cycles, release, ADD stream:
//   - Fetch=1 at cycle 1; decode at 2; execute at 3; writeback at 4, then every cycle.
// - BR nzp=111 fetched at t, nzp=010:
//   - updatepc=0 at t..t+2; t+3 updatepc=1, br_taken=1; fetch resumes t+4.
//   - Same with cond=100: br_taken=0.
// - LDI in E, complete_data after 2 and 3 cycles:
//   - mem_state 3->1(2 cyc)->0(3 cyc)->3; all enables 0 meanwhile.
//   - enable_writeback=1 the cycle after the last complete_data.
// - STR, complete_data after 1 cycle:
//   - mem_state=2 one cycle; enable_writeback never asserted for the store.
// - Reset asserted mid MEM_RD:
//   - Next cycle mem_state=3, all enables 0; stray complete_data ignored.
// - Macro on, MEM_TIMEOUT=8, complete_data never arrives:
//   - mem_err pulse 8 cycles after MEM_RD entry; fetch resumes next cycle; no writeback.

Source files
------------

// File: rtl/lc3_pipe_controller.sv
// LC3 F/D/E/W pipeline sequencer.
// Stalls fetch behind BR/JMP until the branch resolves, and freezes the pipeline
// while the data-memory FSM serves LD/LDR/LDI/ST/STR/STI.
// Optional data-access timeout is built when LC3_CTRL_MEM_TIMEOUT_EN is defined.
module lc3_pipe_controller #(
  parameter int MEM_TIMEOUT = 32'sd64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] imem_dout,
  input  logic [2:0]  nzp,
  input  logic        complete_data,
  output logic        enable_fetch,
  output logic        enable_updatepc,
  output logic        br_taken,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic [1:0]  mem_state,
  output logic        mem_err
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    BR_WAIT = 3'd1,
    MEM_IND = 3'd2,
    MEM_RD  = 3'd3,
    MEM_WR  = 3'd4
  } state_t;

  state_t     state_r;
  logic       vd_r, ve_r, vw_r;
  logic [6:0] op_d_r, op_e_r, op_w_r;
  logic [2:0] br_cond_r;
  logic       br_jmp_r;
  logic [1:0] br_cnt_r;
  logic       ret_br_r;    // freeze interrupted a branch wait; go back to it afterwards

  logic flow_s, in_mem_s, mem_haz_s, fetch_s, ctrl_haz_s, resolve_s, timeout_s;

  function automatic logic op_regwrite(input logic [3:0] opc);
    case (opc)
      4'b0001, 4'b0101, 4'b1001, 4'b0010, 4'b0110, 4'b1010, 4'b1110: op_regwrite = 1'b1;
      default: op_regwrite = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_mem(input logic [3:0] opc);
    case (opc)
      4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b1011: op_is_mem = 1'b1;
      default: op_is_mem = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [3:0] opc);
    case (opc)
      4'b0010, 4'b0110, 4'b1010: op_is_load = 1'b1;
      default: op_is_load = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_indirect(input logic [3:0] opc);
    case (opc)
      4'b1010, 4'b1011: op_is_indirect = 1'b1;
      default: op_is_indirect = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_ctrl(input logic [3:0] opc);
    case (opc)
      4'b0000, 4'b1100: op_is_ctrl = 1'b1;
      default: op_is_ctrl = 1'b0;
    endcase
  endfunction

  // Memory freeze outranks the control hazard: a mem op in E blocks fetch entirely.
  assign flow_s     = (state_r == RUN) || (state_r == BR_WAIT);
  assign in_mem_s   = (state_r == MEM_IND) || (state_r == MEM_RD) || (state_r == MEM_WR);
  assign mem_haz_s  = flow_s & ve_r & op_is_mem(op_e_r[6:3]);
  assign fetch_s    = (state_r == RUN) & ~mem_haz_s;
  assign ctrl_haz_s = fetch_s & op_is_ctrl(imem_dout[15:12]);
  assign resolve_s  = (state_r == BR_WAIT) & ~mem_haz_s & (br_cnt_r == 2'd2);

`ifdef LC3_CTRL_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT) + 1;
  logic [CW-1:0] tmo_cnt_r;

  assign timeout_s = in_mem_s & ~complete_data & (tmo_cnt_r == CW'(MEM_TIMEOUT - 1));

  // Count cycles spent waiting on the current data access; restart per access.
  always_ff @(posedge clock) begin
    if (reset || !in_mem_s || complete_data || timeout_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + CW'(1);
    end
  end
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = MEM_TIMEOUT;
  assign timeout_s = 1'b0;
`endif

  logic unused_s;
  assign unused_s = ^{op_w_r[2:0], imem_dout[8:0]};

  // Decode the registered pipeline state into stage enables; reset forces the idle pattern.
  always_comb begin
    enable_fetch     = 1'b0;
    enable_updatepc  = 1'b0;
    br_taken         = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    mem_state        = 2'd3;
    mem_err          = 1'b0;
    if (reset) begin
      mem_state = 2'd3;
    end else begin
      enable_fetch     = fetch_s;
      enable_updatepc  = (fetch_s & ~ctrl_haz_s) | resolve_s;
      br_taken         = resolve_s & (br_jmp_r | (|(br_cond_r & nzp)));
      enable_decode    = flow_s & ~mem_haz_s & vd_r;
      enable_execute   = flow_s & ve_r;
      enable_writeback = flow_s & vw_r & op_regwrite(op_w_r[6:3]);
      mem_err          = timeout_s;
      case (state_r)
        MEM_IND: mem_state = 2'd1;
        MEM_RD:  mem_state = 2'd0;
        MEM_WR:  mem_state = 2'd2;
        default: mem_state = 2'd3;
      endcase
    end
  end

  // Pipeline sequencer: advances valids/opcodes, tracks branch wait and memory access phases.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= RUN;
      vd_r      <= 1'b0;
      ve_r      <= 1'b0;
      vw_r      <= 1'b0;
      op_d_r    <= 7'd0;
      op_e_r    <= 7'd0;
      op_w_r    <= 7'd0;
      br_cond_r <= 3'd0;
      br_jmp_r  <= 1'b0;
      br_cnt_r  <= 2'd0;
      ret_br_r  <= 1'b0;
    end else begin
      case (state_r)
        RUN, BR_WAIT: begin
          if (mem_haz_s) begin
            // Address calc happens now; D and E hold, W drains to a bubble.
            vw_r     <= 1'b0;
            ret_br_r <= (state_r == BR_WAIT);
            if (op_is_indirect(op_e_r[6:3])) begin
              state_r <= MEM_IND;
            end else if (op_is_load(op_e_r[6:3])) begin
              state_r <= MEM_RD;
            end else begin
              state_r <= MEM_WR;
            end
          end else begin
            vd_r   <= fetch_s;
            if (fetch_s) begin
              op_d_r <= imem_dout[15:9];
            end
            ve_r   <= vd_r;
            op_e_r <= op_d_r;
            vw_r   <= ve_r;
            op_w_r <= op_e_r;
            if (state_r == RUN) begin
              if (ctrl_haz_s) begin
                state_r   <= BR_WAIT;
                br_cnt_r  <= 2'd0;
                br_cond_r <= imem_dout[11:9];
                br_jmp_r  <= (imem_dout[15:12] == 4'b1100);
              end
            end else if (br_cnt_r == 2'd2) begin
              state_r <= RUN;
            end else begin
              br_cnt_r <= br_cnt_r + 2'd1;
            end
          end
        end
        MEM_IND, MEM_RD, MEM_WR: begin
          if (complete_data) begin
            if (state_r == MEM_IND) begin
              state_r <= op_is_load(op_e_r[6:3]) ? MEM_RD : MEM_WR;
            end else begin
              // Access done: the mem op moves on to W, E empties.
              state_r <= ret_br_r ? BR_WAIT : RUN;
              ve_r    <= 1'b0;
              vw_r    <= 1'b1;
              op_w_r  <= op_e_r;
            end
          end else if (timeout_s) begin
            // Abandoned access: drop the op without writeback.
            state_r <= ret_br_r ? BR_WAIT : RUN;
            ve_r    <= 1'b0;
            vw_r    <= 1'b0;
          end
        end
        default: state_r <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed bench for lc3_pipe_controller: reset, ADD stream, BR/JMP stalls,
// LDI/STR/LD memory freezes, reset during an access, optional timeout.
module tb_lc3_pipe_controller;

  logic        clock;
  logic        reset;
  logic [15:0] imem_dout;
  logic [2:0]  nzp;
  logic        complete_data;
  logic        enable_fetch, enable_updatepc, br_taken;
  logic        enable_decode, enable_execute, enable_writeback;
  logic [1:0]  mem_state;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  // Instructions
  localparam logic [15:0] ADD  = 16'h1042;
  localparam logic [15:0] BR_T = 16'h0E05;  // BRnzp
  localparam logic [15:0] BR_N = 16'h0805;  // BRn
  localparam logic [15:0] JMP  = 16'hC1C0;
  localparam logic [15:0] LDI  = 16'hA200;
  localparam logic [15:0] STR  = 16'h7000;
  localparam logic [15:0] LD   = 16'h2000;

  // Expected {fetch, updatepc, br_taken, decode, execute, writeback, mem_state[1:0], mem_err}
  localparam logic [8:0] E_RST = 9'b000000110;
  localparam logic [8:0] E_F   = 9'b110000110;
  localparam logic [8:0] E_FD  = 9'b110100110;
  localparam logic [8:0] E_FDE = 9'b110110110;
  localparam logic [8:0] E_ALL = 9'b110111110;
  localparam logic [8:0] E_FDW = 9'b110101110;
  localparam logic [8:0] E_T   = 9'b100111110;
  localparam logic [8:0] E_T1  = 9'b000111110;
  localparam logic [8:0] E_T2  = 9'b000011110;
  localparam logic [8:0] E_RT  = 9'b011000110;
  localparam logic [8:0] E_RN  = 9'b010000110;
  localparam logic [8:0] E_IND = 9'b000000010;
  localparam logic [8:0] E_RD  = 9'b000000000;
  localparam logic [8:0] E_WR  = 9'b000000100;
  localparam logic [8:0] E_TMO = 9'b000000001;

  lc3_pipe_controller #(.MEM_TIMEOUT(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .imem_dout        (imem_dout),
    .nzp              (nzp),
    .complete_data    (complete_data),
    .enable_fetch     (enable_fetch),
    .enable_updatepc  (enable_updatepc),
    .br_taken         (br_taken),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .mem_state        (mem_state),
    .mem_err          (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply this cycle's inputs at the falling edge and let outputs settle.
  task automatic cyc(input logic [15:0] instr, input logic cd, input logic rst);
    @(negedge clock);
    imem_dout     = instr;
    complete_data = cd;
    reset         = rst;
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {enable_fetch, enable_updatepc, br_taken, enable_decode, enable_execute,
           enable_writeback, mem_state, mem_err};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; imem_dout = ADD; nzp = 3'b010; complete_data = 1'b0;

    // Reset held 3 cycles
    cyc(ADD, 1'b0, 1'b1); chk("reset0", E_RST);
    cyc(ADD, 1'b0, 1'b1); chk("reset1", E_RST);
    cyc(ADD, 1'b0, 1'b1); chk("reset2", E_RST);

    // ADD stream fills the pipe
    cyc(ADD, 1'b0, 1'b0); chk("add_c1", E_F);
    cyc(ADD, 1'b0, 1'b0); chk("add_c2", E_FD);
    cyc(ADD, 1'b0, 1'b0); chk("add_c3", E_FDE);
    cyc(ADD, 1'b0, 1'b0); chk("add_c4", E_ALL);
    cyc(ADD, 1'b0, 1'b0); chk("add_c5", E_ALL);

    // BRnzp with nzp=010: taken
    cyc(BR_T, 1'b0, 1'b0); chk("brt_t0", E_T);
    cyc(ADD, 1'b0, 1'b0);  chk("brt_t1", E_T1);
    cyc(ADD, 1'b0, 1'b0);  chk("brt_t2", E_T2);
    cyc(ADD, 1'b0, 1'b0);  chk("brt_t3", E_RT);
    cyc(ADD, 1'b0, 1'b0);  chk("brt_t4", E_F);
    cyc(ADD, 1'b0, 1'b0);  chk("brt_t5", E_FD);
    cyc(ADD, 1'b0, 1'b0);  chk("brt_t6", E_FDE);
    cyc(ADD, 1'b0, 1'b0);  chk("brt_t7", E_ALL);

    // BRn with nzp=010: not taken
    cyc(BR_N, 1'b0, 1'b0); chk("brn_t0", E_T);
    cyc(ADD, 1'b0, 1'b0);  chk("brn_t1", E_T1);
    cyc(ADD, 1'b0, 1'b0);  chk("brn_t2", E_T2);
    cyc(ADD, 1'b0, 1'b0);  chk("brn_t3", E_RN);
    cyc(ADD, 1'b0, 1'b0);  chk("brn_t4", E_F);
    cyc(ADD, 1'b0, 1'b0);  chk("brn_t5", E_FD);
    cyc(ADD, 1'b0, 1'b0);  chk("brn_t6", E_FDE);
    cyc(ADD, 1'b0, 1'b0);  chk("brn_t7", E_ALL);

    // JMP is always taken, even with nzp=000
    nzp = 3'b000;
    cyc(JMP, 1'b0, 1'b0); chk("jmp_t0", E_T);
    cyc(ADD, 1'b0, 1'b0); chk("jmp_t1", E_T1);
    cyc(ADD, 1'b0, 1'b0); chk("jmp_t2", E_T2);
    cyc(ADD, 1'b0, 1'b0); chk("jmp_t3", E_RT);
    cyc(ADD, 1'b0, 1'b0); chk("jmp_t4", E_F);
    cyc(ADD, 1'b0, 1'b0); chk("jmp_t5", E_FD);
    cyc(ADD, 1'b0, 1'b0); chk("jmp_t6", E_FDE);
    cyc(ADD, 1'b0, 1'b0); chk("jmp_t7", E_ALL);
    nzp = 3'b010;

    // LDI: indirect phase 2 cycles, read phase 3 cycles
    cyc(LDI, 1'b0, 1'b0); chk("ldi_f", E_ALL);
    cyc(ADD, 1'b0, 1'b0); chk("ldi_d", E_ALL);
    cyc(ADD, 1'b0, 1'b0); chk("ldi_e", E_T2);
    cyc(ADD, 1'b0, 1'b0); chk("ldi_ind0", E_IND);
    cyc(ADD, 1'b1, 1'b0); chk("ldi_ind1", E_IND);
    cyc(ADD, 1'b0, 1'b0); chk("ldi_rd0", E_RD);
    cyc(ADD, 1'b0, 1'b0); chk("ldi_rd1", E_RD);
    cyc(ADD, 1'b1, 1'b0); chk("ldi_rd2", E_RD);
    cyc(ADD, 1'b0, 1'b0); chk("ldi_wb", E_FDW);
    cyc(ADD, 1'b0, 1'b0); chk("ldi_r1", E_FDE);
    cyc(ADD, 1'b0, 1'b0); chk("ldi_r2", E_ALL);

    // STR: write phase 1 cycle, never written back
    cyc(STR, 1'b0, 1'b0); chk("str_f", E_ALL);
    cyc(ADD, 1'b0, 1'b0); chk("str_d", E_ALL);
    cyc(ADD, 1'b0, 1'b0); chk("str_e", E_T2);
    cyc(ADD, 1'b1, 1'b0); chk("str_wr", E_WR);
    cyc(ADD, 1'b0, 1'b0); chk("str_nowb", E_FD);
    cyc(ADD, 1'b0, 1'b0); chk("str_r1", E_FDE);
    cyc(ADD, 1'b0, 1'b0); chk("str_r2", E_ALL);

    // LD interrupted by reset in the read phase; stray complete_data ignored
    cyc(LD, 1'b0, 1'b0);  chk("ldr_f", E_ALL);
    cyc(ADD, 1'b0, 1'b0); chk("ldr_d", E_ALL);
    cyc(ADD, 1'b0, 1'b0); chk("ldr_e", E_T2);
    cyc(ADD, 1'b0, 1'b0); chk("ldr_rd", E_RD);
    cyc(ADD, 1'b0, 1'b1); chk("ldr_rst0", E_RST);
    cyc(ADD, 1'b1, 1'b1); chk("ldr_rst1", E_RST);
    cyc(ADD, 1'b1, 1'b0); chk("ldr_c1", E_F);
    cyc(ADD, 1'b0, 1'b0); chk("ldr_c2", E_FD);
    cyc(ADD, 1'b0, 1'b0); chk("ldr_c3", E_FDE);
    cyc(ADD, 1'b0, 1'b0); chk("ldr_c4", E_ALL);

`ifdef LC3_CTRL_MEM_TIMEOUT_EN
    // LD whose access never completes: abort after 8 cycles in the read phase
    cyc(LD, 1'b0, 1'b0);  chk("tmo_f", E_ALL);
    cyc(ADD, 1'b0, 1'b0); chk("tmo_d", E_ALL);
    cyc(ADD, 1'b0, 1'b0); chk("tmo_e", E_T2);
    for (int i = 0; i < 7; i++) begin
      cyc(ADD, 1'b0, 1'b0); chk("tmo_wait", E_RD);
    end
    cyc(ADD, 1'b0, 1'b0); chk("tmo_err", E_TMO);
    cyc(ADD, 1'b0, 1'b0); chk("tmo_resume", E_FD);
    cyc(ADD, 1'b0, 1'b0); chk("tmo_nowb", E_FDE);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
